// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache for the IF stage: hit lookup, miss stall,
// line refill over a request/valid memory handshake, fence.i invalidate and hit/miss counters.
module icache_refill_ctrl #(
    parameter int unsigned LINE_ADDR_LEN = 2,
    parameter int unsigned SET_ADDR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [29:0] rd_addr,
    input  logic        invalidate,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_rd_req,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned ADDR_W       = 30;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned TAG_ADDR_LEN = ADDR_W - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int unsigned NUM_SETS     = 1 << SET_ADDR_LEN;
    localparam int unsigned NUM_WORDS    = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);
    localparam int unsigned IDX_W        = SET_ADDR_LEN + LINE_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t                    state;
    logic [NUM_SETS-1:0]       valid;
    logic                      inv_pending;
    logic [LINE_ADDR_LEN-1:0]  word_cnt;
    logic [TAG_ADDR_LEN-1:0]   miss_tag;
    logic [SET_ADDR_LEN-1:0]   miss_set;

    logic [DATA_W-1:0]         data_arr [NUM_WORDS];
    logic [TAG_ADDR_LEN-1:0]   tag_arr  [NUM_SETS];

    logic [LINE_ADDR_LEN-1:0]  req_off;
    logic [SET_ADDR_LEN-1:0]   req_set;
    logic [TAG_ADDR_LEN-1:0]   req_tag;
    logic [IDX_W-1:0]          req_idx;
    logic [IDX_W-1:0]          fill_idx;
    logic [LINE_ADDR_LEN-1:0]  next_cnt;
    logic                      hit;
    logic                      last_word;

    // Fetch address decode
    always_comb begin
        req_off  = rd_addr[LINE_ADDR_LEN-1:0];
        req_set  = rd_addr[LINE_ADDR_LEN +: SET_ADDR_LEN];
        req_tag  = rd_addr[ADDR_W-1 -: TAG_ADDR_LEN];
        req_idx  = {req_set, req_off};
        fill_idx = {miss_set, word_cnt};
        next_cnt = word_cnt + LINE_ADDR_LEN'(1);
        last_word = (word_cnt == {LINE_ADDR_LEN{1'b1}});
    end

    // Lookup only in IDLE; the stall is raised in the same cycle as the request
    always_comb begin
        hit     = (state == IDLE) && rd_req && valid[req_set] && (tag_arr[req_set] == req_tag);
        rd_data = hit ? data_arr[req_idx] : '0;
        miss    = ((state == IDLE) && rd_req && !hit) || (state != IDLE);
    end

    // Control state, valid bits, handshake outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            inv_pending <= 1'b0;
            word_cnt    <= '0;
            miss_tag    <= '0;
            miss_set    <= '0;
            mem_rd_req  <= 1'b0;
            mem_addr    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (invalidate) begin
                        valid <= '0;
                    end
                    if (rd_req && !hit) begin
                        miss_tag   <= req_tag;
                        miss_set   <= req_set;
                        word_cnt   <= '0;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {req_tag, req_set, LINE_ADDR_LEN'(0)};
                        miss_count <= miss_count + 32'd1;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                    if (mem_rd_valid) begin
                        word_cnt <= next_cnt;
                        mem_addr <= {miss_tag, miss_set, next_cnt};
                        if (last_word) begin
                            mem_rd_req <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A fence.i seen during the refill also drops the line just filled
                    if (inv_pending || invalidate) begin
                        valid <= '0;
                    end else begin
                        valid[miss_set] <= 1'b1;
                    end
                    inv_pending <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage; contents survive reset and are masked by the valid bits
    always_ff @(posedge clk) begin
        if (!rst && (state == FILL) && mem_rd_valid) begin
            data_arr[fill_idx] <= mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (state == DONE)) begin
            tag_arr[miss_set] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios plus random traffic, checked every
// cycle against a line-level cache model, with a few literal expectations.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [29:0] rd_addr;
    logic        invalidate;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_rd_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .invalidate   (invalidate),
        .rd_data      (rd_data),
        .miss         (miss),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Cache model: lines, outstanding refill and pending commit
    bit          mv [16];
    logic [23:0] mt [16];
    logic [31:0] md [64];
    bit          busy = 0;
    bit          commit = 0;
    bit          inv_pend = 0;
    bit          known = 0;
    bit          since_reset = 0;
    int          got = 0;
    logic [29:0] fill_base = '0;
    logic [31:0] hc = '0;
    logic [31:0] mc = '0;

    int gap_target = 0;
    int gap_cnt = 0;
    bit rand_gap = 0;
    logic [29:0] cap_q [$];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return 32'(a) * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void clear_valid();
        foreach (mv[i]) mv[i] = 1'b0;
    endfunction

    // One clock: drive memory, compare at negedge, advance the model at the edge
    task automatic tick();
        bit          idle, e_hit, v;
        logic [3:0]  s;
        logic [23:0] t;
        logic [1:0]  o;
        if (busy) v = (gap_cnt >= gap_target);
        else      v = ($urandom_range(7) == 0);
        mem_rd_valid = v;
        mem_rd_data  = (busy && v) ? mem_word(fill_base + 30'(got)) : $urandom;
        @(negedge clk);
        s = rd_addr[5:2];
        t = rd_addr[29:6];
        o = rd_addr[1:0];
        idle  = !busy && !commit;
        e_hit = idle && rd_req && mv[s] && (mt[s] == t);
        if (known) begin
            chk("miss", 32'(miss), 32'((idle && rd_req && !e_hit) || !idle));
            chk("rd_data", rd_data, e_hit ? md[{s, o}] : 32'h0);
            chk("mem_rd_req", 32'(mem_rd_req), 32'(busy));
            if (busy) chk("mem_addr", 32'(mem_addr), 32'(fill_base + 30'(got)));
            else if (since_reset) chk("mem_addr_rst", 32'(mem_addr), 32'h0);
            chk("hit_count", hit_count, hc);
            chk("miss_count", miss_count, mc);
        end
        if (busy && v) cap_q.push_back(mem_addr);
        if (rst) begin
            clear_valid();
            busy = 0; commit = 0; inv_pend = 0; got = 0;
            hc = '0; mc = '0; gap_cnt = 0;
            known = 1; since_reset = 1;
        end else if (known) begin
            if (e_hit) hc = hc + 32'd1;
            if (idle) begin
                if (invalidate) clear_valid();
                if (rd_req && !e_hit) begin
                    busy = 1; got = 0; fill_base = {t, s, 2'b00};
                    mc = mc + 32'd1; since_reset = 0; gap_cnt = 0;
                    if (rand_gap) gap_target = $urandom_range(3);
                end
            end else if (busy) begin
                if (invalidate) inv_pend = 1;
                if (v) begin
                    md[{fill_base[5:2], 2'(got)}] = mem_word(fill_base + 30'(got));
                    got++;
                    gap_cnt = 0;
                    if (rand_gap) gap_target = $urandom_range(3);
                    if (got == 4) begin busy = 0; commit = 1; end
                end else begin
                    gap_cnt++;
                end
            end else begin
                if (inv_pend || invalidate) clear_valid();
                else begin
                    mv[fill_base[5:2]] = 1'b1;
                    mt[fill_base[5:2]] = fill_base[29:6];
                end
                inv_pend = 0;
                commit = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input int limit);
        int n = 0;
        while ((busy || commit) && n < limit) begin
            tick();
            n++;
        end
        if (busy || commit) begin
            n_checks++;
            n_fails++;
            $display("FAIL fill_timeout: refill still open after %0d cycles, required done", limit);
        end
    endtask

    task automatic start_read(input logic [29:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        run_fill(200);
    endtask

    initial begin
        int n;
        rst = 1'b1; rd_req = 1'b0; invalidate = 1'b0; rd_addr = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        @(posedge clk); #1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        chk("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Cold miss with a word every third cycle
        gap_target = 2;
        rd_req = 1'b1; rd_addr = 30'h104;
        #1 chk("cold_miss_same_cycle", 32'(miss), 32'd1);
        cap_q.delete();
        tick();
        run_fill(100);
        chk("cold_fill_words", 32'(cap_q.size()), 32'd4);
        if (cap_q.size() == 4) begin
            chk("cold_addr0", 32'(cap_q[0]), 32'h104);
            chk("cold_addr1", 32'(cap_q[1]), 32'h105);
            chk("cold_addr2", 32'(cap_q[2]), 32'h106);
            chk("cold_addr3", 32'(cap_q[3]), 32'h107);
        end
        chk("cold_hit_miss", 32'(miss), 32'd0);
        chk("cold_hit_data", rd_data, mem_word(30'h104));
        chk("cold_miss_count", miss_count, 32'd1);

        // Back-to-back hit sweep over the line
        for (int i = 0; i < 4; i++) begin
            rd_addr = 30'h104 + 30'(i);
            tick();
        end
        rd_req = 1'b0;
        chk("sweep_hit_count", hit_count, 32'd4);
        chk("sweep_no_mem_req", 32'(mem_rd_req), 32'd0);

        // Conflict in the same set
        start_read(30'h504);
        rd_req = 1'b1; rd_addr = 30'h104;
        #1 chk("conflict_remiss", 32'(miss), 32'd1);
        tick();
        run_fill(100);
        rd_req = 1'b0;
        tick();
        chk("conflict_miss_count", miss_count, 32'd3);

        // fence.i in IDLE
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        rd_req = 1'b1; rd_addr = 30'h104;
        #1 chk("inv_idle_miss", 32'(miss), 32'd1);
        tick();
        run_fill(100);
        rd_req = 1'b0;
        tick();

        // fence.i during a refill
        rd_req = 1'b1; rd_addr = 30'h208;
        tick();
        rd_req = 1'b0;
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        run_fill(100);
        rd_req = 1'b1;
        #1 chk("inv_fill_miss", 32'(miss), 32'd1);
        tick();
        run_fill(100);
        rd_req = 1'b0;
        tick();

        // Reset after two of four words
        gap_target = 1;
        rd_req = 1'b1; rd_addr = 30'h30C;
        tick();
        n = 0;
        while (got < 2 && n < 50) begin tick(); n++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mem_rd_req", 32'(mem_rd_req), 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);
        chk("midrst_miss", 32'(miss), 32'd1);
        cap_q.delete();
        tick();
        run_fill(100);
        chk("midrst_refill_words", 32'(cap_q.size()), 32'd4);
        if (cap_q.size() > 0) chk("midrst_first_addr", 32'(cap_q[0]), 32'h30C);

        // Request withdrawn mid-fill
        rd_req = 1'b1; rd_addr = 30'h410;
        tick();
        rd_req = 1'b0;
        run_fill(100);
        tick();
        tick();
        rd_req = 1'b1; rd_addr = 30'h413;
        #1 chk("drop_later_hit", 32'(miss), 32'd0);
        chk("drop_hit_data", rd_data, mem_word(30'h413));
        tick();

        // Random traffic
        rand_gap = 1;
        for (int c = 0; c < 2500; c++) begin
            rst        = ($urandom_range(299) == 0);
            invalidate = ($urandom_range(49) == 0);
            rd_req     = ($urandom_range(9) < 7);
            if ($urandom_range(3) != 0)
                rd_addr = (30'($urandom_range(3)) << 6) | 30'($urandom_range(63));
            tick();
        end
        rst = 1'b0; rd_req = 1'b0; invalidate = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
